isp_stream_arbiter: RTL

ISP_STREAM_ARBITER -- requirements
Module: isp_stream_arbiter

---
 rtl/isp_stream_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/isp_stream_arbiter.sv
// Three-source AXI-Stream packet arbiter (pixel/aidat/thumb) feeding the SDRAM writer.
// Define ISP_ARB_FIXPRIO_EN for fixed priority 0>1>2 instead of round-robin.
module isp_stream_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic        system_clock,
  input  logic        system_rstn,
  input  logic        sof,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [15:0] s0_tdata,
  input  logic [1:0]  s0_tstrb,
  input  logic        s0_tlast,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [15:0] s1_tdata,
  input  logic [1:0]  s1_tstrb,
  input  logic        s1_tlast,
  input  logic        s2_tvalid,
  output logic        s2_tready,
  input  logic [15:0] s2_tdata,
  input  logic [1:0]  s2_tstrb,
  input  logic        s2_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] m_tdata,
  output logic [1:0]  m_tstrb,
  output logic        m_tlast,
  output logic [1:0]  m_tid,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sof_pend_q, sof_pend_d;

  logic [2:0]  s_tvalid;
  logic        sg_tvalid, sg_tlast;
  logic [15:0] sg_tdata;
  logic [1:0]  sg_tstrb;
  logic [1:0]  start, pick, grant_next;
  logic        pick_valid, xfer, pkt_end, timeout_hit;

  assign s_tvalid = {s2_tvalid, s1_tvalid, s0_tvalid};

  always_comb begin
    sg_tvalid = 1'b0;
    sg_tlast  = 1'b0;
    sg_tdata  = '0;
    sg_tstrb  = '0;
    unique case (grant_q)
      2'd0: begin
        sg_tvalid = s0_tvalid;
        sg_tlast  = s0_tlast;
        sg_tdata  = s0_tdata;
        sg_tstrb  = s0_tstrb;
      end
      2'd1: begin
        sg_tvalid = s1_tvalid;
        sg_tlast  = s1_tlast;
        sg_tdata  = s1_tdata;
        sg_tstrb  = s1_tstrb;
      end
      2'd2: begin
        sg_tvalid = s2_tvalid;
        sg_tlast  = s2_tlast;
        sg_tdata  = s2_tdata;
        sg_tstrb  = s2_tstrb;
      end
      default: ;
    endcase
  end

`ifdef ISP_ARB_FIXPRIO_EN
  assign start = 2'd0;
`else
  // A same-cycle sof restarts the rotation at source 0 before arbitrating.
  assign start = sof ? 2'd0 : ptr_q;
`endif

  // Walk candidates from the farthest down to start so the nearest valid one wins.
  always_comb begin
    logic [2:0] idx;
    pick       = 2'd0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = {1'b0, start} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (s_tvalid[idx[1:0]]) begin
        pick       = idx[1:0];
        pick_valid = 1'b1;
      end
    end
  end

  assign grant_next  = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
  assign xfer        = (state_q == StGrant) && sg_tvalid && m_tready;
  assign pkt_end     = xfer && sg_tlast;
  assign timeout_hit = (state_q == StGrant) && !sg_tvalid &&
                       (cnt_q == CntW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge system_clock or negedge system_rstn) begin
    if (!system_rstn) begin
      state_q    <= StIdle;
      grant_q    <= 2'd0;
      ptr_q      <= 2'd0;
      cnt_q      <= '0;
      sof_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      sof_pend_q <= sof_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    sof_pend_d = sof_pend_q;
    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        sof_pend_d = 1'b0;
        if (sof) ptr_d = 2'd0;
        if (pick_valid) begin
          state_d = StGrant;
          grant_d = pick;
        end
      end
      StGrant: begin
        sof_pend_d = sof_pend_q | sof;
        if (pkt_end || timeout_hit) begin
          state_d    = StIdle;
          ptr_d      = (sof_pend_q || sof) ? 2'd0 : grant_next;
          sof_pend_d = 1'b0;
          cnt_d      = '0;
        end else if (xfer) begin
          cnt_d = '0;
        end else if (!sg_tvalid) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tstrb     = '0;
    m_tlast     = 1'b0;
    m_tid       = 2'd0;
    busy        = 1'b0;
    err_timeout = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    s2_tready   = 1'b0;
    if (state_q == StGrant) begin
      m_tvalid    = sg_tvalid;
      m_tdata     = sg_tdata;
      m_tstrb     = sg_tstrb;
      m_tlast     = sg_tlast;
      m_tid       = grant_q;
      busy        = 1'b1;
      err_timeout = timeout_hit;
      s0_tready   = (grant_q == 2'd0) && m_tready;
      s1_tready   = (grant_q == 2'd1) && m_tready;
      s2_tready   = (grant_q == 2'd2) && m_tready;
    end
  end

endmodule
